// File: rtl/noc_route_split.sv
`default_nettype none
// ============================================================================
// Module   : noc_route_split
// Purpose  : Input-port splitter for a 4x4 mesh NoC router. Buffers incoming
//            11-bit flits in a small FIFO and XY-routes the head flit to one
//            of five outputs (east, west, north, south, local core). For each
//            flit it first sends a requester-ID token to the chosen output's
//            arbiter, then presents the flit to that output's merge.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            in_data/valid/ready  - upstream flit link ([10:7] dest {y,x})
//            out_data/valid/ready - flit to merges (valid one-hot per output)
//            ctl_data/valid/ready - token (PORT_ID) to arbiters (one-hot)
//            idle                 - FIFO empty and no flit in flight
//            stat_cnt             - five 16-bit saturating delivery counters,
//                                   [15:0]=east .. [79:64]=core (only when
//                                   ROUTE_STATS_EN is defined)
// Options  : `define ROUTE_STATS_EN to add the delivery counters.
// Revision : 1.0 - initial release
// ============================================================================
module noc_route_split #(
  parameter logic [3:0] MY_ADDR = 4'd0,
  parameter logic [2:0] PORT_ID = 3'b000,
  parameter int         DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic [4:0]  out_valid,
  input  logic [4:0]  out_ready,
  output logic [2:0]  ctl_data,
  output logic [4:0]  ctl_valid,
  input  logic [4:0]  ctl_ready,
  output logic        idle
`ifdef ROUTE_STATS_EN
  ,
  output logic [79:0] stat_cnt
`endif
);

  localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TOK  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // XY dimension-order routing: X is resolved completely before Y.
  // Result is one-hot: [0]=east [1]=west [2]=north [3]=south [4]=core.
  function automatic logic [4:0] route(input logic [3:0] dest);
    logic [4:0] dir;
    if (dest[1:0] > MY_ADDR[1:0])      dir = 5'b00001;
    else if (dest[1:0] < MY_ADDR[1:0]) dir = 5'b00010;
    else if (dest[3:2] > MY_ADDR[3:2]) dir = 5'b00100;
    else if (dest[3:2] < MY_ADDR[3:2]) dir = 5'b01000;
    else                               dir = 5'b10000;
    return dir;
  endfunction

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [10:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [10:0]      head;
  logic [10:0]      next_head;

  assign in_ready   = (count_q != C_FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  // Head after the current pop. With only one entry left, the new head can
  // only be a flit being pushed in this same cycle, which is not yet in mem.
  assign next_head  = (count_q > C_ONE) ? mem_q[rd_ptr_nxt] : in_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_nxt;
    case ({push, pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Dispatch FSM: token first, then data. The head flit stays in the FIFO
  // until its data handshake; flit_q/dir_q hold a stable copy for output.
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [4:0]  dir_q, dir_d;
  logic [10:0] flit_q, flit_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    flit_d  = flit_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          flit_d  = head;
          dir_d   = route(head[10:7]);
          state_d = S_TOK;
        end
      end
      S_TOK: begin
        if ((ctl_ready & dir_q) != 5'b0) state_d = S_DATA;
      end
      S_DATA: begin
        if ((out_ready & dir_q) != 5'b0) begin
          pop = 1'b1;
          // Chain straight into the next token when something remains.
          if ((count_q > C_ONE) || push) begin
            flit_d  = next_head;
            dir_d   = route(next_head[10:7]);
            state_d = S_TOK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      flit_q  <= flit_d;
    end
  end

  // Valids decode straight from state so an async reset drops them at once.
  assign ctl_valid = (state_q == S_TOK)  ? dir_q : 5'b0;
  assign out_valid = (state_q == S_DATA) ? dir_q : 5'b0;
  assign ctl_data  = PORT_ID;
  assign out_data  = flit_q;
  assign idle      = (count_q == '0) && (state_q == S_IDLE);

  // --------------------------------------------------------------------------
  // Optional per-direction delivery counters (saturating)
  // --------------------------------------------------------------------------
`ifdef ROUTE_STATS_EN
  for (genvar i = 0; i < 5; i++) begin : g_stat
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (out_valid[i] && out_ready[i] && (cnt_q != 16'hFFFF))
        cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign stat_cnt[16*i +: 16] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_route_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_route_split
// Purpose  : Self-checking bench for noc_route_split. A queue-based model of
//            the buffered flits and the XY routing rule predicts every token,
//            delivery, in_ready and idle value; directed scenarios are
//            followed by a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_route_split;

  localparam logic [3:0] MY_ADDR = 4'b0101;
  localparam logic [2:0] PORT_ID = 3'b010;
  localparam int         DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] out_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [2:0]  ctl_data;
  logic [4:0]  ctl_valid;
  logic [4:0]  ctl_ready;
  logic        idle;
`ifdef ROUTE_STATS_EN
  logic [79:0] stat_cnt;
`endif

  noc_route_split #(
    .MY_ADDR(MY_ADDR),
    .PORT_ID(PORT_ID),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ctl_data (ctl_data),
    .ctl_valid(ctl_valid),
    .ctl_ready(ctl_ready),
    .idle     (idle)
`ifdef ROUTE_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference routing from signed coordinate differences.
  function automatic logic [4:0] ref_route(input logic [3:0] dest);
    int dx, dy;
    dx = int'(dest[1:0]) - int'(MY_ADDR[1:0]);
    dy = int'(dest[3:2]) - int'(MY_ADDR[3:2]);
    if (dx > 0)      return 5'b00001;
    else if (dx < 0) return 5'b00010;
    else if (dy > 0) return 5'b00100;
    else if (dy < 0) return 5'b01000;
    else             return 5'b10000;
  endfunction

  // ---------------------------------------------------------------- model
  logic [10:0] q[$];          // flits held by the port, oldest first
  bit          tok_done;      // token for q[0] already accepted
  bit          hold;          // out_valid was up last cycle without handshake
  logic [10:0] hold_data;
  logic [4:0]  dlog[$];       // delivered directions
  logic [10:0] olog[$];       // delivered flits
  int          exp_stat[5];

  task automatic model_clear();
    q.delete();
    tok_done = 0;
    hold     = 0;
    for (int i = 0; i < 5; i++) exp_stat[i] = 0;
  endtask

  // Checks run mid-cycle; handshakes seen here complete on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      int          n;
      logic [10:0] h;
      n = q.size();
      h = (n > 0) ? q[0] : 11'h0;
      check("in_ready", in_ready, n < DEPTH);
      check("idle", idle, n == 0);
      check("onehot", $countones(ctl_valid | out_valid) <= 1, 1);
      check("ctl_data", ctl_data, PORT_ID);
      if (ctl_valid != 5'b0) begin
        if (n == 0) check("ctl_spurious", ctl_valid, 0);
        else begin
          check("ctl_dir", ctl_valid, ref_route(h[10:7]));
          check("tok_repeat", tok_done, 0);
        end
      end
      if (out_valid != 5'b0) begin
        if (n == 0) check("out_spurious", out_valid, 0);
        else begin
          check("out_dir", out_valid, ref_route(h[10:7]));
          check("out_data", out_data, h);
          check("tok_before_data", tok_done, 1);
          if (hold) check("out_stable", out_data, hold_data);
        end
      end
      hold = 0;
      if ((ctl_valid & ctl_ready) != 5'b0) tok_done = 1;
      if ((out_valid & out_ready) != 5'b0) begin
        dlog.push_back(out_valid);
        olog.push_back(out_data);
        for (int i = 0; i < 5; i++)
          if (out_valid[i] && exp_stat[i] < 16'hFFFF) exp_stat[i]++;
        if (n > 0) void'(q.pop_front());
        tok_done = 0;
      end else if (out_valid != 5'b0) begin
        hold      = 1;
        hold_data = out_data;
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic push_flit(input logic [10:0] f);
    int g;
    g = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = f;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("push_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 5'h1F;
    ctl_ready = 5'h1F;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check({tag, "_drained"}, q.size(), 0);
    @(negedge clk);
  endtask

  logic [10:0] flits[5];
  logic [4:0]  exp_dirs[4];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;
    ctl_ready = '0;
    model_clear();

    // Reset state
    #22;
    check("rst_in_ready", in_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ctl_valid", ctl_valid, 0);
    #1 rst_n = 1'b1;

    // Single east flit, readies high: latency and payload
    out_ready = 5'h1F;
    ctl_ready = 5'h1F;
    push_flit({4'b0111, 7'h2A});
    @(negedge clk);
    check("lat_idle_cycle", ctl_valid, 0);
    @(negedge clk);
    check("t1_ctl_valid", ctl_valid, 5'b00001);
    check("t1_ctl_data", ctl_data, PORT_ID);
    @(negedge clk);
    check("t1_out_valid", out_valid, 5'b00001);
    check("t1_out_data", out_data, {4'b0111, 7'h2A});
    drain("t1");

    // North, south, core, then west (X before Y)
    dlog.delete();
    flits[0] = {4'b1001, 7'h11};
    flits[1] = {4'b0001, 7'h22};
    flits[2] = {4'b0101, 7'h33};
    flits[3] = {4'b1000, 7'h44};
    exp_dirs = '{5'b00100, 5'b01000, 5'b10000, 5'b00010};
    for (int i = 0; i < 4; i++) push_flit(flits[i]);
    drain("t2");
    check("t2_count", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++)
      check($sformatf("t2_dir%0d", i), dlog[i], exp_dirs[i]);

    // Fill to full with output stalled, then release
    olog.delete();
    out_ready = 5'h00;
    ctl_ready = 5'h1F;
    for (int i = 0; i < 5; i++) flits[i] = {4'(i * 5 + 2), 7'(i * 19 + 3)};
    for (int i = 0; i < 4; i++) push_flit(flits[i]);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = flits[4];
    @(negedge clk);
    check("t3_full", in_ready, 0);
    repeat (3) @(negedge clk);
    check("t3_still_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 5'h1F;
    @(negedge clk);
    @(negedge clk);
    check("t3_ready_after_pop", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("t3");
    check("t3_count", olog.size(), 5);
    for (int i = 0; i < 5 && i < olog.size(); i++)
      check($sformatf("t3_order%0d", i), olog[i], flits[i]);

    // Token backpressure on north
    dlog.delete();
    out_ready = 5'h1F;
    ctl_ready = 5'b11011;
    push_flit({4'b1101, 7'h5A});
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_ctl_held", ctl_valid, 5'b00100);
      check("t4_no_out", out_valid, 0);
      check("t4_data_stable", out_data, {4'b1101, 7'h5A});
    end
    drain("t4");
    check("t4_delivered", dlog.size(), 1);

    // Reset while a flit sits in DATA
    out_ready = 5'h00;
    ctl_ready = 5'h1F;
    push_flit({4'b0110, 7'h07});
    for (int i = 0; i < 20 && out_valid == 5'b0; i++) @(negedge clk);
    check("t5_in_data", out_valid, 5'b00001);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_ctl_valid", ctl_valid, 0);
    model_clear();
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_after", idle, 1);
    check("t5_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 5'h1F;
    repeat (5) @(negedge clk);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 11'($urandom);
      for (int b = 0; b < 5; b++) begin
        out_ready[b] = ($urandom_range(0, 3) != 0);
        ctl_ready[b] = ($urandom_range(0, 3) != 0);
      end
    end
    drain("rand");

`ifdef ROUTE_STATS_EN
    for (int i = 0; i < 5; i++)
      check($sformatf("stat%0d", i), stat_cnt[16*i +: 16], exp_stat[i]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
